// File: rtl/idli_pkg.sv
// Shared types and default sizes for the serial register file.
package idli_pkg;

  typedef enum logic {
    SRF_IDLE = 1'b0,
    SRF_RUN  = 1'b1
  } srf_state_t;

  localparam int SRF_NUM_REGS = 8;
  localparam int SRF_WIDTH    = 16;

endpackage

// File: rtl/idli_srf_ctl_m.sv
// Serial register file control: transaction FSM, bit counter and the
// per-transaction index / write-enable latches. Start is honoured when idle
// or on the done cycle, so transactions can run back-to-back with no bubble.
module idli_srf_ctl_m
  import idli_pkg::*;
#(
  parameter int NUM_REGS = SRF_NUM_REGS,
  parameter int WIDTH    = SRF_WIDTH,
  localparam int IW      = $clog2(NUM_REGS),
  localparam int BW      = $clog2(WIDTH)
) (
  input  logic          i_gck,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [IW-1:0] i_p,
  input  logic [IW-1:0] i_q,
  input  logic          i_wr_en,
  output srf_state_t    o_state,
  output logic [IW-1:0] o_p,
  output logic [IW-1:0] o_q,
  output logic          o_wr_en,
  output logic          o_busy,
  output logic          o_done,
  output logic [BW-1:0] o_bit
);

  srf_state_t    r_state;
  srf_state_t    w_state_nxt;
  logic [BW-1:0] r_bit;
  logic [BW-1:0] w_bit_nxt;
  logic [IW-1:0] r_p;
  logic [IW-1:0] w_p_nxt;
  logic [IW-1:0] r_q;
  logic [IW-1:0] w_q_nxt;
  logic          r_wr_en;
  logic          w_wr_en_nxt;
  logic          w_last;

  assign w_last = (r_bit == BW'(WIDTH - 1));

  // State, counter and latched transaction fields.
  always_ff @(posedge i_gck or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SRF_IDLE;
      r_bit   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_p     <= w_p_nxt;
      r_q     <= w_q_nxt;
      r_wr_en <= w_wr_en_nxt;
    end
  end

  // Next-state: launch on start, count bits, relaunch or stop at the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_p_nxt     = r_p;
    w_q_nxt     = r_q;
    w_wr_en_nxt = r_wr_en;
    case (r_state)
      SRF_IDLE: begin
        if (i_start) begin
          w_state_nxt = SRF_RUN;
          w_bit_nxt   = '0;
          w_p_nxt     = i_p;
          w_q_nxt     = i_q;
          w_wr_en_nxt = i_wr_en;
        end
      end
      SRF_RUN: begin
        if (w_last) begin
          w_bit_nxt = '0;
          if (i_start) begin
            w_p_nxt     = i_p;
            w_q_nxt     = i_q;
            w_wr_en_nxt = i_wr_en;
          end else begin
            w_state_nxt = SRF_IDLE;
          end
        end else begin
          w_bit_nxt = r_bit + BW'(1);
        end
      end
      default: begin
        w_state_nxt = SRF_IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  assign o_state = r_state;
  assign o_p     = r_p;
  assign o_q     = r_q;
  assign o_wr_en = r_wr_en;
  assign o_busy  = (r_state == SRF_RUN);
  assign o_done  = (r_state == SRF_RUN) && w_last;
  assign o_bit   = r_bit;

endmodule

// File: rtl/idli_srf_m.sv
// Bit-serial register file: NUM_REGS-1 writable registers plus a constant
// register at the top index, streamed LSB-first one bit per cycle.
// Optional build macro IDLI_SRF_FWD_EN: forwards the incoming write bit onto
// the P read port when P and Q name the same writable register.
module idli_srf_m
  import idli_pkg::*;
#(
  parameter int               NUM_REGS  = SRF_NUM_REGS,
  parameter int               WIDTH     = SRF_WIDTH,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(16'hFFFF),
  localparam int              IW        = $clog2(NUM_REGS),
  localparam int              BW        = $clog2(WIDTH)
) (
  input  logic          i_srf_gck,
  input  logic          i_srf_rst,
  input  logic          i_srf_start,
  input  logic [IW-1:0] i_srf_p,
  input  logic [IW-1:0] i_srf_q,
  input  logic          i_srf_q_wr_en,
  input  logic          i_srf_q_data,
  output logic          o_srf_p_data,
  output logic          o_srf_q_data,
  output logic          o_srf_busy,
  output logic          o_srf_done,
  output logic [BW-1:0] o_srf_bit
);

  srf_state_t    w_state;
  logic [IW-1:0] w_p;
  logic [IW-1:0] w_q;
  logic          w_wr_en;
  logic [BW-1:0] w_bit;
  logic          w_run;
  logic          w_p_store;
  logic          w_q_store;
  logic          w_q_wr_ok;

  logic [WIDTH-1:0] r_regs [NUM_REGS-1];

  idli_srf_ctl_m #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH)
  ) u_ctl (
    .i_gck   (i_srf_gck),
    .i_rst   (i_srf_rst),
    .i_start (i_srf_start),
    .i_p     (i_srf_p),
    .i_q     (i_srf_q),
    .i_wr_en (i_srf_q_wr_en),
    .o_state (w_state),
    .o_p     (w_p),
    .o_q     (w_q),
    .o_wr_en (w_wr_en),
    .o_busy  (o_srf_busy),
    .o_done  (o_srf_done),
    .o_bit   (w_bit)
  );

  assign w_run     = (w_state == SRF_RUN);
  assign o_srf_bit = w_bit;

  // A write only lands on a writable index; the constant and any
  // out-of-range index silently drop it.
  assign w_q_wr_ok = w_run && w_wr_en && (int'(w_q) < NUM_REGS - 1);

  // Stored-bit read muxes for both ports, including the constant register.
  always_comb begin
    w_p_store = 1'b0;
    w_q_store = 1'b0;
    if (int'(w_p) == NUM_REGS - 1) begin
      w_p_store = CONST_VAL[w_bit];
    end else if (int'(w_p) < NUM_REGS - 1) begin
      w_p_store = r_regs[w_p][w_bit];
    end
    if (int'(w_q) == NUM_REGS - 1) begin
      w_q_store = CONST_VAL[w_bit];
    end else if (int'(w_q) < NUM_REGS - 1) begin
      w_q_store = r_regs[w_q][w_bit];
    end
  end

  // Register storage: one bit written per cycle; reset discards partial writes.
  always_ff @(posedge i_srf_gck or posedge i_srf_rst) begin
    if (i_srf_rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_q_wr_ok) begin
      r_regs[w_q][w_bit] <= i_srf_q_data;
    end
  end

  // Q always shows the pre-write bit; data outputs are quiet outside RUN.
  assign o_srf_q_data = w_run & w_q_store;

`ifdef IDLI_SRF_FWD_EN
  assign o_srf_p_data = w_run & ((w_q_wr_ok && (w_p == w_q)) ? i_srf_q_data : w_p_store);
`else
  assign o_srf_p_data = w_run & w_p_store;
`endif

endmodule

// File: tb/tb_idli_srf_m.sv
// Bench for idli_srf_m: transaction-level model of the register contents,
// per-cycle output comparison and literal word checks for the named scenarios.
module tb_idli_srf_m;

  localparam int          NR = 8;
  localparam int          W  = 16;
  localparam logic [W-1:0] CV = 16'hFFFF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [2:0] p_idx = '0;
  logic [2:0] q_idx = '0;
  logic       q_wr  = 1'b0;
  logic       q_din = 1'b0;
  logic       o_p_data;
  logic       o_q_data;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_bit;

  idli_srf_m dut (
    .i_srf_gck     (clk),
    .i_srf_rst     (rst),
    .i_srf_start   (start),
    .i_srf_p       (p_idx),
    .i_srf_q       (q_idx),
    .i_srf_q_wr_en (q_wr),
    .i_srf_q_data  (q_din),
    .o_srf_p_data  (o_p_data),
    .o_srf_q_data  (o_q_data),
    .o_srf_busy    (o_busy),
    .o_srf_done    (o_done),
    .o_srf_bit     (o_bit)
  );

  // Scoreboard state
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic exp_pd   = 1'b0;
  logic exp_qd   = 1'b0;
  logic [3:0] exp_bit = '0;
  logic [W-1:0] model_regs [NR-1];
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_read(input int idx);
    if (idx == NR - 1) return CV;
    if (idx < NR - 1) return model_regs[idx];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR - 1; i++) model_regs[i] = '0;
  endtask

  task automatic exp_idle();
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_bit  = '0;
    exp_pd   = 1'b0;
    exp_qd   = 1'b0;
  endtask

  // Per-cycle compare, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   {31'd0, o_busy},   {31'd0, exp_busy});
      check("done",   {31'd0, o_done},   {31'd0, exp_done});
      check("bit",    {28'd0, o_bit},    {28'd0, exp_bit});
      check("p_data", {31'd0, o_p_data}, {31'd0, exp_pd});
      check("q_data", {31'd0, o_q_data}, {31'd0, exp_qd});
    end
  end

  // Driver: called at a point between edges; raises start, then streams W bits.
  // abort_at >= 0 asserts reset during that bit cycle.
  task automatic txn(input int p, input int q, input bit wr, input logic [W-1:0] data,
                     input int abort_at, output logic [W-1:0] obs_p, output logic [W-1:0] obs_q);
    logic [W-1:0] pv;
    logic [W-1:0] qv;
    pv = model_read(p);
    qv = model_read(q);
`ifdef IDLI_SRF_FWD_EN
    if (p == q && wr && q < NR - 1) pv = data;
`endif
    exp_q.push_back(pv);
    start = 1'b1;
    p_idx = 3'(p);
    q_idx = 3'(q);
    q_wr  = wr;
    obs_p = '0;
    obs_q = '0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      q_din = data[k];
      if (k == abort_at) begin
        rst = 1'b1;
        exp_idle();
        #1;
        check("busy_async_reset", {31'd0, o_busy}, 32'd0);
        model_clear();
        void'(exp_q.pop_back());
        return;
      end
      exp_busy = 1'b1;
      exp_done = (k == W - 1);
      exp_bit  = 4'(k);
      exp_pd   = pv[k];
      exp_qd   = qv[k];
      #2;
      obs_p[k] = o_p_data;
      obs_q[k] = o_q_data;
    end
    check("p_word", {16'd0, obs_p}, {16'd0, exp_q.pop_front()});
    if (wr && q < NR - 1) model_regs[q] = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      q_wr  = 1'b0;
      exp_idle();
    end
  endtask

  logic [W-1:0] op;
  logic [W-1:0] oq;

  initial begin
    model_clear();
    exp_idle();
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_busy",  {31'd0, o_busy},   32'd0);
    check("rst_done",  {31'd0, o_done},   32'd0);
    check("rst_bit",   {28'd0, o_bit},    32'd0);
    check("rst_pdata", {31'd0, o_p_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fresh registers read zero, back-to-back
    for (int p = 0; p < NR - 1; p++) begin
      txn(p, 0, 1'b0, 16'($urandom), -1, op, oq);
      check("t1_zero", {16'd0, op}, 32'd0);
    end
    idle(2);

    // Write r3 then read it
    txn(0, 3, 1'b1, 16'hA5C3, -1, op, oq);
    idle(1);
    txn(3, 0, 1'b0, 16'h0000, -1, op, oq);
    check("t2_r3", {16'd0, op}, 32'h0000A5C3);
    idle(1);

    // Constant register ignores writes
    txn(7, 0, 1'b0, 16'h1111, -1, op, oq);
    check("t3_const", {16'd0, op}, 32'h0000FFFF);
    txn(0, 7, 1'b1, 16'h0000, -1, op, oq);
    check("t3_const_q", {16'd0, oq}, 32'h0000FFFF);
    txn(7, 0, 1'b0, 16'h2222, -1, op, oq);
    check("t3_const_after", {16'd0, op}, 32'h0000FFFF);

    // Back-to-back: bit wraps 15->0 while busy stays high
    txn(3, 1, 1'b0, 16'h0F0F, -1, op, oq);
    txn(1, 3, 1'b0, 16'hF0F0, -1, op, oq);
    check("t4_b2b_q", {16'd0, oq}, 32'h0000A5C3);
    idle(1);

    // Same-register read/write
    txn(0, 2, 1'b1, 16'hFFFF, -1, op, oq);
    idle(1);
    txn(2, 2, 1'b1, 16'h1234, -1, op, oq);
    check("t5_q_old", {16'd0, oq}, 32'h0000FFFF);
`ifdef IDLI_SRF_FWD_EN
    check("t5_p_fwd", {16'd0, op}, 32'h00001234);
`else
    check("t5_p_old", {16'd0, op}, 32'h0000FFFF);
`endif
    idle(1);
    txn(2, 0, 1'b0, 16'h0000, -1, op, oq);
    check("t5_r2_new", {16'd0, op}, 32'h00001234);
    idle(1);

    // Reset in the middle of a write
    txn(0, 4, 1'b1, 16'h00FF, 5, op, oq);
    idle(2);
    rst = 1'b0;
    idle(1);
    txn(4, 2, 1'b0, 16'h0000, -1, op, oq);
    check("t6_r4", {16'd0, op}, 32'd0);
    check("t6_r2_cleared", {16'd0, oq}, 32'd0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      txn(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
          bit'($urandom_range(0, 1)), 16'($urandom), -1, op, oq);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
